// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming pooling layer.
//   pool_mode_t  : reduction select (max / average)
//   pool_state_t : frame FSM states
//   acc_width()  : accumulator width needed to sum 2**shift samples of 'bits'
package pool_pkg;

  typedef enum logic {
    POOL_MAX = 1'b0,
    POOL_AVG = 1'b1
  } pool_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pool_state_t;

  function automatic int unsigned acc_width(input int unsigned bits, input int unsigned shift);
    return bits + shift;
  endfunction

endpackage

// File: rtl/pool_stream_layer_lane.sv
// One pooling lane: accumulator plus result register.
// Optional average datapath is built when POOL_AVG_EN is defined.
// Ports:
//   clk_in, rst_n        : clock, async active-low reset
//   first, last, acc_en  : window strobes from the frame controller
//   mode                 : latched reduction mode
//   sample               : this lane's signed input sample
//   result               : registered pooled output (held until next window)
module pool_lane
  import pool_pkg::*;
#(
  parameter int unsigned BITS  = 16,
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             first,
  input  logic             last,
  input  logic             acc_en,
  input  pool_mode_t       mode,
  input  logic [BITS-1:0]  sample,
  output logic [BITS-1:0]  result
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic        [BITS-1:0]  res_d;

`ifdef POOL_AVG_EN
  assign sample_ext = {{(ACC_W-BITS){sample[BITS-1]}}, sample};
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign sample_ext  = sample;
`endif

  // Next accumulator value including the current sample.
  always_comb begin
    acc_d = acc_q;
    if (first) begin
      acc_d = sample_ext;
`ifdef POOL_AVG_EN
    end else if (mode == POOL_AVG) begin
      acc_d = acc_q + sample_ext;
`endif
    end else if (sample_ext > acc_q) begin
      acc_d = sample_ext;
    end
  end

  // Average: arithmetic shift floors toward minus infinity.
  always_comb begin
    res_d = acc_d[BITS-1:0];
`ifdef POOL_AVG_EN
    if (mode == POOL_AVG) res_d = BITS'(acc_d >>> (ACC_W - BITS));
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      result <= '0;
    end else if (acc_en) begin
      acc_q <= acc_d;
      if (last) result <= res_d;
    end
  end

endmodule

// File: rtl/pool_stream_layer.sv
// Multi-channel streaming pooling layer: reduces each run of 2**POOL_SHIFT
// valid samples per lane to one result, max or average (average only when
// POOL_AVG_EN is defined), with per-frame start/ready/done bookkeeping.
// Ports:
//   clk_in, rst_n : clock, async active-low reset
//   start, mode   : arm/restart a frame, mode latched on start
//   in_valid, data_in   : one sample per lane per valid cycle
//   data_out, out_valid : pooled lanes and their one-cycle strobe
//   ready, done         : armed (RUN) flag, end-of-frame pulse
module pool_stream_layer
  import pool_pkg::*;
#(
  parameter int unsigned BITS       = 16,
  parameter int unsigned POOL_SHIFT = 2,
  parameter int unsigned CHANNELS   = 16,
  parameter int unsigned FRAME_LEN  = 64
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     in_valid,
  input  logic [CHANNELS*BITS-1:0] data_in,
  output logic [CHANNELS*BITS-1:0] data_out,
  output logic                     out_valid,
  output logic                     ready,
  output logic                     done
);

  localparam int unsigned POOL  = 1 << POOL_SHIFT;
  localparam int unsigned NWIN  = FRAME_LEN / POOL;
  localparam int unsigned IDX_W = (NWIN > 1) ? $clog2(NWIN) : 1;
`ifdef POOL_AVG_EN
  localparam int unsigned ACC_W = acc_width(BITS, POOL_SHIFT);
`else
  localparam int unsigned ACC_W = BITS;
`endif

  pool_state_t           state_q, state_d;
  pool_mode_t            mode_q, mode_d, mode_sel;
  logic [POOL_SHIFT-1:0] win_cnt_q, win_cnt_d;
  logic [IDX_W-1:0]      win_idx_q, win_idx_d;
  logic                  frame_end_q, frame_end_d;
  logic                  out_valid_d, ready_d, done_d;
  logic                  acc_en, first, last;

`ifdef POOL_AVG_EN
  assign mode_sel = pool_mode_t'(mode);
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign mode_sel    = POOL_MAX;
`endif

  // Lane strobes; a start in the same cycle drops the sample.
  assign acc_en = (state_q == ST_RUN) && in_valid && !start && !frame_end_q;
  assign first  = (win_cnt_q == '0);
  assign last   = (win_cnt_q == POOL_SHIFT'(POOL - 1));

  // Next state; frame_end holds RUN for the cycle the final result is shown,
  // so done follows the last out_valid by one cycle.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    win_cnt_d   = win_cnt_q;
    win_idx_d   = win_idx_q;
    frame_end_d = frame_end_q;
    out_valid_d = 1'b0;
    if (start) begin
      state_d     = ST_RUN;
      mode_d      = mode_sel;
      win_cnt_d   = '0;
      win_idx_d   = '0;
      frame_end_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (frame_end_q) begin
            state_d     = ST_DONE;
            frame_end_d = 1'b0;
          end else if (acc_en) begin
            win_cnt_d = win_cnt_q + POOL_SHIFT'(1);
            if (last) begin
              out_valid_d = 1'b1;
              if (win_idx_q == IDX_W'(NWIN - 1)) begin
                frame_end_d = 1'b1;
                win_idx_d   = '0;
              end else begin
                win_idx_d = win_idx_q + IDX_W'(1);
              end
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
    ready_d = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= POOL_MAX;
      win_cnt_q   <= '0;
      win_idx_q   <= '0;
      frame_end_q <= 1'b0;
      out_valid   <= 1'b0;
      ready       <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      win_cnt_q   <= win_cnt_d;
      win_idx_q   <= win_idx_d;
      frame_end_q <= frame_end_d;
      out_valid   <= out_valid_d;
      ready       <= ready_d;
      done        <= done_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    pool_lane #(
      .BITS  (BITS),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .first  (first),
      .last   (last),
      .acc_en (acc_en),
      .mode   (mode_q),
      .sample (data_in[c*BITS +: BITS]),
      .result (data_out[c*BITS +: BITS])
    );
  end

endmodule

// File: tb/tb_pool_stream_layer.sv
// Self-checking bench for pool_stream_layer (FRAME_LEN=8, 4 lanes, window 4).
// Average expectations apply only when POOL_AVG_EN is defined.
module tb_pool_stream_layer;

  localparam int unsigned BITS       = 16;
  localparam int unsigned POOL_SHIFT = 2;
  localparam int unsigned POOL       = 4;
  localparam int unsigned CHANNELS   = 4;
  localparam int unsigned FRAME_LEN  = 8;
  localparam int unsigned DW         = CHANNELS * BITS;
`ifdef POOL_AVG_EN
  localparam bit AVG_ON = 1'b1;
`else
  localparam bit AVG_ON = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n, start, mode, in_valid;
  logic [DW-1:0] data_in, data_out;
  logic          out_valid, ready, done;

  int            errors = 0;
  int            checks = 0;
  int            ov_count = 0;
  int            base;
  logic [DW-1:0] win [POOL];
  logic [DW-1:0] exp_d;

  pool_stream_layer #(
    .BITS(BITS), .POOL_SHIFT(POOL_SHIFT), .CHANNELS(CHANNELS), .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .mode(mode), .in_valid(in_valid),
    .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .ready(ready), .done(done)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (out_valid === 1'b1) ov_count++;

  // Reference: per lane, max of the window or floor(sum / POOL).
  function automatic logic [DW-1:0] model(input logic [DW-1:0] s [POOL], input logic m);
    logic [DW-1:0] r;
    int v, acc, q;
    r = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      acc = 0;
      for (int k = 0; k < int'(POOL); k++) begin
        v = int'($signed(s[k][c*BITS +: BITS]));
        if (AVG_ON && m) acc += v;
        else if (k == 0 || v > acc) acc = v;
      end
      if (AVG_ON && m) begin
        q = acc / int'(POOL);
        if ((acc % int'(POOL)) != 0 && acc < 0) q--;
      end else begin
        q = acc;
      end
      r[c*BITS +: BITS] = BITS'(q);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int c = 0; c < int'(CHANNELS); c++) r[c*BITS +: BITS] = BITS'($urandom);
    return r;
  endfunction

  function automatic logic [DW-1:0] splat(input int val);
    logic [DW-1:0] r;
    for (int c = 0; c < int'(CHANNELS); c++) r[c*BITS +: BITS] = BITS'(val);
    return r;
  endfunction

  task automatic step(input logic v, input logic [DW-1:0] d, input logic s, input logic m);
    in_valid = v; data_in = d; start = s; mode = m;
    @(posedge clk_in); #1;
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; data_in = '0;
    #2 rst_n = 1'b0;
    #10;
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    @(negedge clk_in) rst_n = 1'b1;
    base = ov_count;
    repeat (4) step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got=%b exp=0", ready); end
    checks++; if (ov_count - base !== 0) begin errors++; $display("FAIL idle_no_output got=%0d exp=0", ov_count - base); end
  endtask

  task automatic test_max();
    step(1'b0, '0, 1'b1, 1'b0);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL max_ready_rise got=%b exp=1", ready); end
    for (int k = 0; k < int'(POOL); k++) win[k] = rnd();
    win[0][BITS-1:0] = BITS'(3);
    win[1][BITS-1:0] = BITS'(-5);
    win[2][BITS-1:0] = BITS'(9);
    win[3][BITS-1:0] = BITS'(2);
    exp_d = model(win, 1'b0);
    for (int k = 0; k < int'(POOL); k++) begin
      step(1'b1, win[k], 1'b0, 1'b0);
      if (k == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_early_valid got=%b exp=0", out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL max_valid got=%b exp=1", out_valid); end
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL max_data got=%h exp=%h", data_out, exp_d); end
    checks++; if (data_out[BITS-1:0] !== BITS'(9)) begin errors++; $display("FAIL max_lane0 got=%0d exp=9", $signed(data_out[BITS-1:0])); end
    step(1'b0, rnd(), 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL max_valid_pulse got=%b exp=0", out_valid); end
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL max_hold got=%h exp=%h", data_out, exp_d); end
  endtask

  task automatic test_avg();
    step(1'b0, '0, 1'b1, 1'b1);
    for (int k = 0; k < int'(POOL); k++) win[k] = rnd();
    win[0][BITS-1:0] = BITS'(-1);   win[0][2*BITS-1:BITS] = BITS'(4);
    win[1][BITS-1:0] = BITS'(-2);   win[1][2*BITS-1:BITS] = BITS'(4);
    win[2][BITS-1:0] = BITS'(-2);   win[2][2*BITS-1:BITS] = BITS'(4);
    win[3][BITS-1:0] = BITS'(-2);   win[3][2*BITS-1:BITS] = BITS'(5);
    exp_d = model(win, 1'b1);
    for (int k = 0; k < int'(POOL); k++) step(1'b1, win[k], 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_valid got=%b exp=1", out_valid); end
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL avg_data got=%h exp=%h", data_out, exp_d); end
  endtask

  task automatic test_frame();
    logic m;
    m = 1'($urandom_range(0, 1));
    step(1'b0, '0, 1'b1, m);
    base = ov_count;
    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < int'(POOL); k++) begin
        win[k] = rnd();
        step(1'b1, win[k], 1'b0, 1'b0);
      end
      exp_d = model(win, m);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL frame_valid w=%0d got=%b exp=1", w, out_valid); end
      checks++; if (data_out !== exp_d) begin errors++; $display("FAIL frame_data w=%0d got=%h exp=%h", w, data_out, exp_d); end
    end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_early got=%b exp=0", done); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL frame_done got=%b exp=1", done); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL frame_ready_fall got=%b exp=0", ready); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL frame_done_pulse got=%b exp=0", done); end
    checks++; if (ov_count - base !== 2) begin errors++; $display("FAIL frame_pulses got=%0d exp=2", ov_count - base); end
    base = ov_count;
    repeat (4) step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (ov_count - base !== 0) begin errors++; $display("FAIL after_frame_idle got=%0d exp=0", ov_count - base); end
  endtask

  task automatic test_restart();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, splat(1000), 1'b0, 1'b0);
    step(1'b1, splat(1000), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    base = ov_count;
    for (int k = 0; k < int'(POOL); k++) begin
      win[k] = splat(1);
      step(1'b1, win[k], 1'b0, 1'b0);
    end
    exp_d = model(win, 1'b0);
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL restart_data got=%h exp=%h", data_out, exp_d); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (ov_count - base !== 1) begin errors++; $display("FAIL restart_pulses got=%0d exp=1", ov_count - base); end
  endtask

  task automatic test_start_collision();
    step(1'b1, splat(100), 1'b1, 1'b0);
    base = ov_count;
    for (int k = 0; k < int'(POOL); k++) begin
      win[k] = splat(0);
      step(1'b1, win[k], 1'b0, 1'b0);
      if (k == 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL collide_early got=%b exp=0", out_valid); end
      end
    end
    exp_d = model(win, 1'b0);
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL collide_data got=%h exp=%h", data_out, exp_d); end
    step(1'b0, '0, 1'b0, 1'b0);
    checks++; if (ov_count - base !== 1) begin errors++; $display("FAIL collide_pulses got=%0d exp=1", ov_count - base); end
  endtask

  task automatic test_random();
    logic m;
    for (int f = 0; f < 4; f++) begin
      m = 1'($urandom_range(0, 1));
      step(1'b0, '0, 1'b1, m);
      for (int w = 0; w < 2; w++) begin
        for (int k = 0; k < int'(POOL); k++) begin
          repeat ($urandom_range(0, 2)) step(1'b0, rnd(), 1'b0, 1'b0);
          win[k] = rnd();
          step(1'b1, win[k], 1'b0, 1'b0);
        end
        exp_d = model(win, m);
        checks++; if (out_valid !== 1'b1 || data_out !== exp_d) begin
          errors++; $display("FAIL rand_window f=%0d w=%0d got=%b/%h exp=1/%h", f, w, out_valid, data_out, exp_d);
        end
      end
      step(1'b0, '0, 1'b0, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL rand_done f=%0d got=%b exp=1", f, done); end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < int'(POOL); k++) step(1'b1, splat(7), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    step(1'b1, rnd(), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (data_out !== '0) begin errors++; $display("FAIL arst_data got=%h exp=0", data_out); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL arst_ready got=%b exp=0", ready); end
    checks++; if (out_valid !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL arst_strobes got=%b%b exp=00", out_valid, done);
    end
    @(negedge clk_in) rst_n = 1'b1;
    base = ov_count;
    repeat (5) step(1'b1, rnd(), 1'b0, 1'b0);
    checks++; if (ready !== 1'b0 || ov_count - base !== 0) begin
      errors++; $display("FAIL arst_idle got=ready%b/pulses%0d exp=ready0/pulses0", ready, ov_count - base);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < int'(POOL); k++) begin
      win[k] = rnd();
      step(1'b1, win[k], 1'b0, 1'b0);
    end
    exp_d = model(win, 1'b0);
    checks++; if (data_out !== exp_d) begin errors++; $display("FAIL arst_recover got=%h exp=%h", data_out, exp_d); end
  endtask

  initial begin
    test_reset();
    test_max();
    test_avg();
    test_frame();
    test_restart();
    test_start_collision();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pool_stream_layer.md
# pool_stream_layer

Parametrised multi-channel streaming pooling layer, successor to the fixed-size per-channel max-pool layer. It accepts one packed sample per channel per valid cycle and reduces each run of `2**POOL_SHIFT` consecutive samples to one result per channel. The reduction is runtime-selectable between max and average. Frame bookkeeping is built in, and the block sits between a convolution layer's output bus and the next layer's input.

## Interface
- `BITS`, 16, signed two's-complement sample width per channel
- `POOL_SHIFT`, 2, log2 of window length; `POOL = 1<<POOL_SHIFT` (legal 1..4)
- `CHANNELS`, 16, number of parallel lanes
- `FRAME_LEN`, 64, samples per channel per frame; must be a multiple of `POOL`

- `clk_in`, input, 1, single clock, rising edge
- `rst_n`, input, 1, reset; asynchronous and active-low
- `start`, input, 1, one-cycle pulse that arms a new frame
- `mode`, input, 1, 0 = max, 1 = average; sampled only on `start`
- `in_valid`, input, 1, `data_in` carries one sample per lane this cycle
- `data_in`, input, `CHANNELS*BITS`, lane i at bits `[i*BITS +: BITS]`
- `data_out`, output, `CHANNELS*BITS`, pooled results in the same lane layout
- `out_valid`, output, 1, one-cycle strobe; `data_out` holds a new result
- `ready`, output, 1, high while armed (RUN state)
- `done`, output, 1, one-cycle pulse after the last result of a frame

## Operation
- FSM states:
  - IDLE: `in_valid` is ignored. `start` goes to RUN and latches `mode`.
  - RUN: accepts samples. The last sample of the frame goes to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- Counters:
  - Window counter `win_cnt` is `POOL_SHIFT` bits wide.
  - Window counter `win_idx` counts 0..`FRAME_LEN/POOL-1`.
  - Both clear on `start`.
- Max mode:
  - The first sample of a window loads the lane accumulator.
  - Each later sample replaces it if the sample is signed-greater.
- Average mode:
  - The lane accumulator is `BITS+POOL_SHIFT` bits wide and is sign-extended.
  - The first sample loads it, and later samples add to it.
  - Result is the accumulator arithmetically shifted right by `POOL_SHIFT`, which is floor toward −∞. No overflow is possible.
- Window completion: on the `in_valid` cycle where `win_cnt == POOL-1`, the lane result registers into `data_out` and `out_valid` asserts.
- `data_out` holds its value until the next result.
- `start` during RUN or DONE restarts the frame:
  - The partial window is discarded and emits no `out_valid`.
  - Counters clear and `mode` is re-latched.
- `start` and `in_valid` in the same cycle: `start` wins and that sample is dropped.
- Gaps in `in_valid` are allowed. The window spans valid cycles, not clock cycles.

## Timing
- Reset values: `data_out` = 0, `out_valid` = 0, `ready` = 0, `done` = 0, state = IDLE, accumulators = 0.
- `ready` rises the cycle after `start` is sampled.
- Latency: `out_valid` asserts on the clock edge that samples the window's last valid input, so it is visible one cycle later.
- `done` asserts in the cycle after the final `out_valid`, while in DONE. `ready` is low in that cycle.
- Throughput: one sample per lane per cycle, with no back-pressure.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). Partial results are lost.

## Configuration
- `POOL_AVG_EN`:
  - Defined: average datapath present and `mode` honoured.
  - Undefined: accumulator is `BITS` wide, `mode` is ignored and the block always max-pools.

## Structure
- Package `pool_pkg`:
  - `pool_mode_t` enum (`POOL_MAX`, `POOL_AVG`)
  - FSM state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`)
  - shared width helper for `BITS+POOL_SHIFT`
- Sub-module `pool_lane`: one per channel, generated `CHANNELS` times.
  - Holds the accumulator and the result register.
  - Driven by shared `first`, `last`, `acc_en` and `mode` strobes from the top FSM.

## Test plan
- Max, `POOL_SHIFT=2`, lane0 inputs 3, −5, 9, 2 → `data_out[15:0]` = 9 with one `out_valid`, one cycle after the 4th sample.
- Average, lane0 inputs −1, −2, −2, −2 → sum −7, result −2 (floor). Lane1 inputs 4, 4, 4, 5 → 4.
- `FRAME_LEN=8`, continuous valid:
  - exactly 2 `out_valid` pulses;
  - `done` one cycle after the second pulse;
  - `ready` falls with `done`;
  - later `in_valid` in IDLE produces nothing.
- Restart: `start` after 2 samples of a window, then 4 samples 1, 1, 1, 1 in max mode → single result 1, with no result from the aborted partial window.
- `start` and `in_valid` in the same cycle with value 100, then 4 samples of 0 → result 0; the 100 is dropped.
- Assert `rst_n` low mid-window → all outputs 0 immediately; after release, the block stays IDLE until `start`.
